// File: rtl/acc_reg_pkg.sv
// Shared CPU constants for the accumulator register: default width and reset contents.
package acc_reg_pkg;

    localparam int unsigned AccWidth  = 8;
    localparam logic        AccRstBit = 1'b0;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } acc_flags_t;

endpackage

// File: rtl/acc_reg_flag_gen.sv
// Status flags derived purely combinationally from the registered accumulator value.
module acc_reg_flag_gen
    import acc_reg_pkg::*;
#(
    parameter int unsigned WIDTH = AccWidth
) (
    input  logic [WIDTH-1:0] val_i,
    output acc_flags_t       flags_o
);

    always_comb begin
        flags_o        = '0;
        flags_o.zero   = ~|val_i;
        flags_o.neg    = val_i[WIDTH-1];
        flags_o.parity = ^val_i;
    end

endmodule

// File: rtl/acc_reg.sv
// Accumulator register with load enable, async active-low clear and zero/neg/parity flags.
module acc_reg
    import acc_reg_pkg::*;
#(
    parameter int unsigned WIDTH = AccWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             regWrite,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             parity
);

    logic [WIDTH-1:0] out_d, out_q;
    acc_flags_t       flags;

    always_comb begin
        out_d = out_q;
        if (regWrite) begin
            out_d = in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {WIDTH{AccRstBit}};
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

    acc_reg_flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .val_i  (out_q),
        .flags_o(flags)
    );

    assign zero   = flags.zero;
    assign neg    = flags.neg;
    assign parity = flags.parity;

endmodule

// File: tb/tb_acc_reg.sv
// Directed walk through the load/hold/reset timeline, then random traffic against a reference model.
module tb_acc_reg;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         regWrite;
    logic [W-1:0] tb_in;
    logic [W-1:0] tb_out;
    logic         tb_zero;
    logic         tb_neg;
    logic         tb_parity;

    int n_vec;
    int n_miscompare;
    int unsigned exp_val;

    acc_reg #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .regWrite(regWrite),
        .in      (tb_in),
        .out     (tb_out),
        .zero    (tb_zero),
        .neg     (tb_neg),
        .parity  (tb_parity)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned count_ones(input int unsigned v);
        int unsigned c = 0;
        int unsigned x = v;
        while (x != 0) begin
            c += x % 2;
            x  = x / 2;
        end
        return c;
    endfunction

    // Compare value and all three flags against the model value.
    task automatic check_all(input string tag, input int unsigned v);
        check_eq({tag, ".out"}, 32'(tb_out), v);
        check_eq({tag, ".zero"}, 32'(tb_zero), 32'(v == 0));
        check_eq({tag, ".neg"}, 32'(tb_neg), 32'(v >= (32'd1 << (W - 1))));
        check_eq({tag, ".parity"}, 32'(tb_parity), count_ones(v) % 2);
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;

        rst_n    = 1'b0;
        regWrite = 1'b0;
        tb_in    = '0;
        #5;
        check_all("in_reset", 0);
        #5;
        rst_n = 1'b1;
        #1;
        check_all("post_release", 0);

        regWrite = 1'b1;
        tb_in    = 8'h00;
        @(posedge clk); #1;
        check_all("load_zero", 8'h00);

        #19;
        tb_in = 8'hAA;
        @(posedge clk); #1;
        check_all("load_aa", 8'hAA);

        #9;
        regWrite = 1'b0;
        tb_in    = 8'h81;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_all("hold_aa", 8'hAA);
        end

        #33;
        rst_n = 1'b0;
        #1;
        check_all("async_clear", 0);
        regWrite = 1'b1;
        tb_in    = 8'h7F;
        @(posedge clk); #1;
        check_all("reset_wins", 0);

        #4;
        rst_n = 1'b1;
        tb_in = 8'h01;
        @(posedge clk); #1;
        check_all("b2b_01", 8'h01);
        tb_in = 8'h80;
        @(posedge clk); #1;
        check_all("b2b_80", 8'h80);
        @(posedge clk); #1;
        check_all("reload_same", 8'h80);

        regWrite = 1'b0;
        tb_in    = 'x;
        @(posedge clk); #1;
        check_all("hold_x_in", 8'h80);

        // Random phase: inputs change at the falling edge, occasional mid-cycle reset pulses.
        exp_val = 8'h80;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            regWrite = 1'($urandom_range(0, 1));
            tb_in    = W'($urandom);
            if (!regWrite && $urandom_range(0, 7) == 0) tb_in = 'x;
            if ($urandom_range(0, 15) == 0) begin
                #5;
                rst_n   = 1'b0;
                exp_val = 0;
                #1;
                check_all("rand_async", exp_val);
                if ($urandom_range(0, 1) == 1) rst_n = 1'b1;
            end
            #7;
            check_all("rand_midcycle", exp_val);
            @(posedge clk);
            if (!rst_n) exp_val = 0;
            else if (regWrite) exp_val = 32'(tb_in);
            #1;
            check_all("rand_edge", exp_val);
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
